// File: rtl/key_bounce_pkg.sv
// Shared types and constants for the bouncy key-press generator.
// Contents:
//   state_t    sequencer states
//   LFSR_W     LFSR width
//   LFSR_TAPS  Galois feedback mask
//   lfsr_step  one right-shifting Galois LFSR step
package key_bounce_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        BNC_PRESS   = 2'd1,
        HOLD        = 2'd2,
        BNC_RELEASE = 2'd3
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// Free-running seeded Galois LFSR that supplies pseudo-random bounce gaps.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset, loads the seed
//   lfsr  out  current LFSR state, advances every cycle
module bounce_lfsr
    import key_bounce_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] lfsr
);

    // An all-zero Galois LFSR never leaves zero.
    localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED_SAFE;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

endmodule

// File: rtl/key_bounce_gen.sv
// Bouncy key-press generator. On start it drives key_out through a bouncing
// press, a clean hold and a bouncing release, like a mechanical button.
// Build option: BOUNCE_FIXED_GAP_EN makes every bounce gap gap_mask+1
// cycles. Without it, each gap is (lfsr & gap_mask)+1 cycles.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   press request, sampled only when idle
//   hold_len    in   clean pressed cycles (0 behaves as 1)
//   bounce_cnt  in   glitches per edge (0 = clean edge)
//   gap_mask    in   mask applied to the LFSR to form the gap length
//   key_out     out  emulated key, 1 = pressed
//   busy        out  high for the whole press sequence
//   done        out  one-cycle pulse after the sequence ends
//
// state       | meaning
// IDLE        | waiting for start, key released
// BNC_PRESS   | press bounce, glitches around level 1
// HOLD        | key held cleanly at 1
// BNC_RELEASE | release bounce, glitches around level 0
module key_bounce_gen
    import key_bounce_pkg::*;
#(
    parameter int                CNT_W = 16,
    parameter int                BNC_W = 4,
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] hold_len,
    input  logic [BNC_W-1:0] bounce_cnt,
    input  logic [CNT_W-1:0] gap_mask,
    output logic             key_out,
    output logic             busy,
    output logic             done
);

    state_t state, state_nxt;

    logic             key_nxt, busy_nxt, done_nxt;
    logic             tgt;
    logic [CNT_W-1:0] tmr, tmr_nxt;
    logic [CNT_W-1:0] hold_q, hold_nxt;
    logic [CNT_W-1:0] mask_q, mask_nxt;
    logic [CNT_W-1:0] mask_sel, gap_raw, gap_val;
    logic [BNC_W-1:0] glc, glc_nxt;
    logic [BNC_W-1:0] bnc_q, bnc_nxt;
    logic [LFSR_W-1:0] lfsr;

    bounce_lfsr #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    function automatic logic [CNT_W-1:0] hold_min(input logic [CNT_W-1:0] h);
        return (h == '0) ? CNT_W'(1) : h;
    endfunction

    // The first gap is computed on the accept edge, before the mask is latched.
    assign mask_sel = (state == IDLE) ? gap_mask : mask_q;

`ifdef BOUNCE_FIXED_GAP_EN
    logic lfsr_unused;
    assign lfsr_unused = ^lfsr;
    assign gap_raw     = mask_sel + CNT_W'(1);
`else
    logic [CNT_W-1:0] lfsr_low;
    assign lfsr_low = CNT_W'(lfsr);
    assign gap_raw  = (lfsr_low & mask_sel) + CNT_W'(1);
`endif

    // An all-ones mask wraps the +1 to zero; a gap is never shorter than 1.
    assign gap_val = (gap_raw == '0) ? CNT_W'(1) : gap_raw;

    // Resting level of the current bounce phase.
    assign tgt = (state == BNC_PRESS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            key_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tmr     <= '0;
            glc     <= '0;
            hold_q  <= '0;
            bnc_q   <= '0;
            mask_q  <= '0;
        end else begin
            state   <= state_nxt;
            key_out <= key_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            tmr     <= tmr_nxt;
            glc     <= glc_nxt;
            hold_q  <= hold_nxt;
            bnc_q   <= bnc_nxt;
            mask_q  <= mask_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = key_out;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        tmr_nxt   = tmr;
        glc_nxt   = glc;
        hold_nxt  = hold_q;
        bnc_nxt   = bnc_q;
        mask_nxt  = mask_q;

        unique case (state)
            IDLE: begin
                if (start) begin
                    hold_nxt = hold_len;
                    bnc_nxt  = bounce_cnt;
                    mask_nxt = gap_mask;
                    busy_nxt = 1'b1;
                    key_nxt  = 1'b1;
                    if (bounce_cnt != '0) begin
                        state_nxt = BNC_PRESS;
                        glc_nxt   = bounce_cnt;
                        tmr_nxt   = gap_val;
                    end else begin
                        state_nxt = HOLD;
                        tmr_nxt   = hold_min(hold_len);
                    end
                end
            end

            BNC_PRESS, BNC_RELEASE: begin
                if (tmr > CNT_W'(1)) begin
                    tmr_nxt = tmr - CNT_W'(1);
                end else if (key_out == tgt) begin
                    // First half of a glitch done: swing away from the resting level.
                    key_nxt = ~tgt;
                    tmr_nxt = gap_val;
                end else if (glc > BNC_W'(1)) begin
                    glc_nxt = glc - BNC_W'(1);
                    key_nxt = tgt;
                    tmr_nxt = gap_val;
                end else if (state == BNC_PRESS) begin
                    state_nxt = HOLD;
                    key_nxt   = 1'b1;
                    glc_nxt   = '0;
                    tmr_nxt   = hold_min(hold_q);
                end else begin
                    state_nxt = IDLE;
                    key_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    glc_nxt   = '0;
                    tmr_nxt   = '0;
                end
            end

            HOLD: begin
                if (tmr > CNT_W'(1)) begin
                    tmr_nxt = tmr - CNT_W'(1);
                end else if (bnc_q != '0) begin
                    state_nxt = BNC_RELEASE;
                    key_nxt   = 1'b0;
                    glc_nxt   = bnc_q;
                    tmr_nxt   = gap_val;
                end else begin
                    state_nxt = IDLE;
                    key_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    tmr_nxt   = '0;
                end
            end

            default: begin
                state_nxt = IDLE;
                key_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Self-checking bench for key_bounce_gen. Each press is predicted as a list
// of per-cycle key levels built from the gap/hold rules, then compared
// cycle by cycle together with busy and done.
module tb_key_bounce_gen;

    localparam int          CNT_W = 16;
    localparam int          BNC_W = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] hold_len;
    logic [BNC_W-1:0] bounce_cnt;
    logic [CNT_W-1:0] gap_mask;
    logic             key_out;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_press  = 0;

    logic [15:0] m_lfsr;

    key_bounce_gen #(
        .CNT_W (CNT_W),
        .BNC_W (BNC_W),
        .SEED  (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hold_len   (hold_len),
        .bounce_cnt (bounce_cnt),
        .gap_mask   (gap_mask),
        .key_out    (key_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        logic [15:0] r;
        r = l >> 1;
        if (l[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Reference LFSR value: what the generator's LFSR holds this cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= lfsr_adv(m_lfsr);
    end

    always @(posedge clk) begin
        if (!rst && done) n_done <= n_done + 1;
    end

    function automatic int model_gap(input logic [15:0] l, input logic [15:0] m);
        int g;
`ifdef BOUNCE_FIXED_GAP_EN
        g = int'(m) + 1 + 0 * int'(l);
`else
        g = int'(l & m) + 1;
`endif
        if (g > 65535) g = 1;
        return g;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One complete press, optionally with start and config noise while busy.
    task automatic run_press(input logic [15:0] h, input logic [3:0] bc,
                             input logic [15:0] m, input bit noisy, input string tag);
        bit          exp_q[$];
        logic [15:0] l;
        int          g;
        int          hold;
        @(negedge clk);
        hold_len   = h;
        bounce_cnt = bc;
        gap_mask   = m;
        start      = 1'b1;
        l          = m_lfsr;
        for (int i = 0; i < 2 * int'(bc); i++) begin
            g = model_gap(l, m);
            for (int k = 0; k < g; k++) begin
                exp_q.push_back(i % 2 == 0);
                l = lfsr_adv(l);
            end
        end
        hold = (h == 16'd0) ? 1 : int'(h);
        for (int k = 0; k < hold; k++) begin
            exp_q.push_back(1'b1);
            l = lfsr_adv(l);
        end
        for (int i = 0; i < 2 * int'(bc); i++) begin
            g = model_gap(l, m);
            for (int k = 0; k < g; k++) begin
                exp_q.push_back(i % 2 == 1);
                l = lfsr_adv(l);
            end
        end
        @(posedge clk);
        foreach (exp_q[j]) begin
            @(negedge clk);
            if (noisy) begin
                start      = 1'($urandom_range(0, 1));
                hold_len   = 16'($urandom);
                bounce_cnt = 4'($urandom);
                gap_mask   = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            check({tag, "_key"}, key_out, exp_q[j]);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_done_early"}, done, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_end_key"}, key_out, 1'b0);
        check({tag, "_end_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b1);
        @(negedge clk);
        check({tag, "_done_width"}, done, 1'b0);
        check({tag, "_idle_busy"}, busy, 1'b0);
        n_press++;
    endtask

    initial begin
        logic [15:0] rmask;
        rst        = 1'b1;
        start      = 1'b0;
        hold_len   = '0;
        bounce_cnt = '0;
        gap_mask   = '0;
        repeat (3) @(negedge clk);
        check("rst_key", key_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_key", key_out, 1'b0);

        run_press(16'd10, 4'd2, 16'd3, 1'b0, "t1");
        run_press(16'd0, 4'd0, 16'd7, 1'b0, "t2");
        run_press(16'd10, 4'd2, 16'd3, 1'b1, "t3");

        // Reset in the middle of the hold: outputs drop at once, no done.
        @(negedge clk);
        hold_len   = 16'd30;
        bounce_cnt = 4'd1;
        gap_mask   = 16'd3;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("t4_hold_key", key_out, 1'b1);
        check("t4_hold_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t4_async_key", key_out, 1'b0);
        check("t4_async_busy", busy, 1'b0);
        check("t4_async_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t4_post_done", done, 1'b0);
            check("t4_post_busy", busy, 1'b0);
        end
        run_press(16'd4, 4'd1, 16'd3, 1'b0, "t4b");

`ifdef BOUNCE_FIXED_GAP_EN
        run_press(16'd5, 4'd1, 16'hFFFF, 1'b0, "t5");
`else
        run_press(16'd5, 4'd1, 16'h000F, 1'b0, "t5");
`endif

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0:       rmask = 16'd0;
                1:       rmask = 16'd1;
                2:       rmask = 16'd3;
                3:       rmask = 16'd7;
                default: rmask = 16'($urandom_range(0, 15));
            endcase
            run_press(16'($urandom_range(0, 12)), 4'($urandom_range(0, 4)), rmask,
                      1'($urandom_range(0, 1)), "rnd");
        end

        check("done_count", n_done, n_press);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
